// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory bus arbiter.
//   arb_state_t   - FSM state encoding (IDLE=0, GRANT=1, OWNED=2, TURN=3)
//   clog2()       - index/counter width helper, never returns less than 1
//   DEF_*         - default parameter values for mem_bus_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWNED = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_t;

    localparam int DEF_NREQ          = 4;
    localparam int DEF_GRANT_TIMEOUT = 16;
    localparam int DEF_WDOG_LIMIT    = 256;

    // Ceiling log2. A width of 1 is the floor so that a 1-bit index or
    // counter is still declarable for the smallest legal parameter values.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req     in  NREQ  request vector
//   rr_ptr  in  IDW   index that has highest priority this round
//   winner  out IDW   first set req bit scanning rr_ptr, rr_ptr+1, ... mod NREQ
//   any_req out 1     at least one request is pending
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    // Rotating a doubled copy right by rr_ptr puts the highest-priority
    // client at bit 0; the lowest set bit is then the offset from rr_ptr.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDW-1:0]    offset;
    logic [IDW:0]      sum;

    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> rr_ptr);
    assign any_req = |req;

    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDW'(i);
            end
        end
    end

    assign sum    = {1'b0, rr_ptr} + {1'b0, offset};
    assign winner = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: central round-robin owner of the shared memory interconnect.
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low (0 = reset)
//   req            in   per-client mem_req (level)
//   busy_in        in   per-client bus_busy_out (level)
//   grant          out  one-hot or zero grant, registered
//   owner_id       out  index of current/last grantee, registered
//   bus_idle       out  high only in IDLE
//   grant_timeout  out  one-cycle pulse when an unused grant is revoked
//   conflict       out  sticky: illegal busy pattern observed
//   wdog_err       out  sticky: owner exceeded the hold limit
// Build option: define MEM_ARB_WATCHDOG_EN to bound how long one client may
// hold busy (WDOG_LIMIT cycles); without it wdog_err is tied low.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int WDOG_LIMIT    = DEF_WDOG_LIMIT,
    localparam int IDW          = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] busy_in,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  owner_id,
    output logic            bus_idle,
    output logic            grant_timeout,
    output logic            conflict,
    output logic            wdog_err
);

    localparam int             GCW       = clog2(GRANT_TIMEOUT);
    localparam logic [GCW-1:0] GCNT_LAST = GCW'(GRANT_TIMEOUT - 1);

    if (NREQ < 2 || NREQ > 8 || GRANT_TIMEOUT < 2 || WDOG_LIMIT < 2) begin : g_bad_params
        $error("mem_bus_arbiter: parameter out of range");
    end

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IDW-1:0]  owner_reg, owner_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [GCW-1:0]  gcnt_reg, gcnt_next;
    logic            timeout_reg, timeout_next;
    logic            conflict_reg, conflict_next;

    logic [IDW-1:0]  winner;
    logic            any_req;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] win_mask;
    logic            owner_busy;
    logic            owner_req;
    logic            conflict_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign owner_mask[gi] = (owner_reg == IDW'(gi));
        assign win_mask[gi]   = (winner == IDW'(gi));
    end

    // Only the owner's req/busy matter outside IDLE.
    assign owner_busy = |(busy_in & owner_mask);
    assign owner_req  = |(req & owner_mask);

    // Illegal busy: more than one line high, a non-owner driving while the
    // bus is allocated, or anyone driving while the bus is idle.
    assign conflict_hit = (|(busy_in & (busy_in - 1'b1)))
                        | ((state_reg != ST_IDLE) & (|(busy_in & ~owner_mask)))
                        | ((state_reg == ST_IDLE) & (|busy_in));

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int             HCW       = clog2(WDOG_LIMIT) + 1;
    localparam logic [HCW-1:0] HCNT_LAST = HCW'(WDOG_LIMIT - 1);

    logic [HCW-1:0] hcnt_reg, hcnt_next;
    logic           wdog_reg, wdog_next;

    assign wdog_err = wdog_reg;
`else
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        gcnt_next     = gcnt_reg;
        timeout_next  = 1'b0;
        conflict_next = conflict_reg | conflict_hit;
`ifdef MEM_ARB_WATCHDOG_EN
        hcnt_next     = hcnt_reg;
        wdog_next     = wdog_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_GRANT;
                    grant_next = win_mask;
                    owner_next = winner;
                    gcnt_next  = '0;
                end
            end
            ST_GRANT: begin
                // Busy beats withdrawal and timeout in the same cycle.
                if (owner_busy) begin
                    state_next = ST_OWNED;
`ifdef MEM_ARB_WATCHDOG_EN
                    hcnt_next  = '0;
`endif
                end else if (!owner_req) begin
                    state_next = ST_TURN;
                    grant_next = '0;
                end else if (gcnt_reg == GCNT_LAST) begin
                    state_next   = ST_TURN;
                    grant_next   = '0;
                    timeout_next = 1'b1;
                end else begin
                    gcnt_next = gcnt_reg + 1'b1;
                end
            end
            ST_OWNED: begin
                if (!owner_busy) begin
                    state_next = ST_TURN;
                    grant_next = '0;
                end
`ifdef MEM_ARB_WATCHDOG_EN
                else if (hcnt_reg == HCNT_LAST) begin
                    state_next = ST_TURN;
                    grant_next = '0;
                    wdog_next  = 1'b1;
                end else if (hcnt_reg != '1) begin
                    hcnt_next = hcnt_reg + 1'b1;
                end
`endif
            end
            ST_TURN: begin
                // One dead cycle with grant low so the old owner's drivers
                // release before anyone else is granted.
                state_next  = ST_IDLE;
                rr_ptr_next = (owner_reg == IDW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            gcnt_reg     <= '0;
            timeout_reg  <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            gcnt_reg     <= gcnt_next;
            timeout_reg  <= timeout_next;
            conflict_reg <= conflict_next;
        end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_reg <= '0;
            wdog_reg <= 1'b0;
        end else begin
            hcnt_reg <= hcnt_next;
            wdog_reg <= wdog_next;
        end
    end
`endif

    assign grant         = grant_reg;
    assign owner_id      = owner_reg;
    assign bus_idle      = (state_reg == ST_IDLE);
    assign grant_timeout = timeout_reg;
    assign conflict      = conflict_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (NREQ=4, GRANT_TIMEOUT=16, WDOG_LIMIT=8).
// Expected grantees are queued when requests are driven and popped when
// the grant appears. Watchdog expectations follow MEM_ARB_WATCHDOG_EN.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] busy_in;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       bus_idle;
    logic       grant_timeout;
    logic       conflict;
    logic       wdog_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int sb_exp;

    mem_bus_arbiter #(
        .NREQ          (4),
        .GRANT_TIMEOUT (16),
        .WDOG_LIMIT    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .busy_in       (busy_in),
        .grant         (grant),
        .owner_id      (owner_id),
        .bus_idle      (bus_idle),
        .grant_timeout (grant_timeout),
        .conflict      (conflict),
        .wdog_err      (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        req     = '0;
        busy_in = '0;
        step();
        step();
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant); end
        n_cmp++; if (owner_id !== 2'd0) begin n_err++; $display("FAIL rst_owner: got %0d want 0", owner_id); end
        n_cmp++; if (bus_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", bus_idle); end
        n_cmp++; if (grant_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", grant_timeout); end
        n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL rst_conflict: got %b want 0", conflict); end
        n_cmp++; if (wdog_err !== 1'b0) begin n_err++; $display("FAIL rst_wdog: got %b want 0", wdog_err); end
        $display("test_reset: outputs at reset grant=%b owner=%0d idle=%b", grant, owner_id, bus_idle);
        reset = 1'b1;
        step();
    endtask

    task automatic test_fairness();
        int gap;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(k % 4);
            gap = 0;
            step();
            while (grant === 4'b0000 && gap < 10) begin
                gap++;
                step();
            end
            sb_exp = exp_q.pop_front();
            n_cmp++;
            if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
                n_err++; $display("FAIL fair_owner: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
            end
            if (k > 0) begin
                n_cmp++;
                if (gap !== 2) begin n_err++; $display("FAIL fair_gap: got %0d idle-grant cycles want 2", gap); end
            end
            $display("test_fairness: round %0d owner=%0d gap=%0d", k, owner_id, gap);
            busy_in = 4'(1 << (k % 4));
            repeat (3) step();
            busy_in = '0;
        end
        req = '0;
        step();
        step();
        n_cmp++; if (bus_idle !== 1'b1) begin n_err++; $display("FAIL fair_end_idle: got %b want 1", bus_idle); end
    endtask

    task automatic test_single();
        req = 4'b0100;
        exp_q.push_back(2);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL single_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        n_cmp++; if (bus_idle !== 1'b0) begin n_err++; $display("FAIL single_busidle: got %b want 0", bus_idle); end
        busy_in = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_hold: cycle %0d got %b want 0100", c, grant); end
        end
        busy_in = '0;
        req     = '0;
        step();
        n_cmp++; if (grant !== 4'b0000 || bus_idle !== 1'b0) begin n_err++; $display("FAIL single_turn: grant=%b idle=%b want 0000/0", grant, bus_idle); end
        step();
        n_cmp++; if (bus_idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b want 1", bus_idle); end
        $display("test_single: owner 2 granted, held 5 cycles, released");
    endtask

    task automatic test_timeout();
        int cnt;
        req = 4'b0110;
        exp_q.push_back(1);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL to_first: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        cnt = 1;
        step();
        while (grant === 4'b0010 && cnt < 40) begin
            cnt++;
            step();
        end
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL to_len: grant high %0d cycles want 16", cnt); end
        n_cmp++; if (grant_timeout !== 1'b1 || grant !== 4'b0000) begin n_err++; $display("FAIL to_pulse: pulse=%b grant=%b want 1/0000", grant_timeout, grant); end
        exp_q.push_back(2);
        step();
        n_cmp++; if (grant_timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_len: got %b want 0", grant_timeout); end
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL to_next: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        req = '0;
        step();
        n_cmp++; if (grant !== 4'b0000 || grant_timeout !== 1'b0) begin n_err++; $display("FAIL to_withdraw: grant=%b pulse=%b want 0000/0", grant, grant_timeout); end
        step();
        $display("test_timeout: grant held %0d cycles before revocation", cnt);
    endtask

    task automatic test_withdraw();
        req = 4'b1000;
        exp_q.push_back(3);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL wd_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        step();
        step();
        n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wd_wait: got %b want 1000", grant); end
        req = '0;
        step();
        n_cmp++; if (grant !== 4'b0000 || grant_timeout !== 1'b0 || bus_idle !== 1'b0) begin
            n_err++; $display("FAIL wd_turn: grant=%b pulse=%b idle=%b want 0000/0/0", grant, grant_timeout, bus_idle);
        end
        step();
        n_cmp++; if (bus_idle !== 1'b1) begin n_err++; $display("FAIL wd_idle: got %b want 1", bus_idle); end
        $display("test_withdraw: request 3 withdrawn during grant");
    endtask

    task automatic test_priority();
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL pri_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        repeat (15) step();
        busy_in = 4'b0001;
        step();
        n_cmp++; if (grant !== 4'b0001 || grant_timeout !== 1'b0) begin
            n_err++; $display("FAIL pri_busy_wins: grant=%b pulse=%b want 0001/0", grant, grant_timeout);
        end
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL pri_owned: got %b want 0001", grant); end
        busy_in = '0;
        req     = '0;
        step();
        n_cmp++; if (grant !== 4'b0000 || grant_timeout !== 1'b0) begin n_err++; $display("FAIL pri_release: grant=%b pulse=%b want 0000/0", grant, grant_timeout); end
        step();
        $display("test_priority: busy on timeout cycle kept the grant");
    endtask

    task automatic test_conflict();
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL cf_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL cf_clean: got %b want 0", conflict); end
        busy_in = 4'b0011;
        step();
        n_cmp++; if (conflict !== 1'b1 || grant !== 4'b0001) begin n_err++; $display("FAIL cf_set: conflict=%b grant=%b want 1/0001", conflict, grant); end
        busy_in = '0;
        req     = '0;
        step();
        step();
        n_cmp++; if (conflict !== 1'b1) begin n_err++; $display("FAIL cf_sticky: got %b want 1", conflict); end
        req = 4'b0100;
        exp_q.push_back(2);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL cf_continue: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        req = '0;
        step();
        step();
        $display("test_conflict: conflict=%b after illegal busy pattern", conflict);
    endtask

    task automatic test_watchdog();
        int held;
        apply_reset();
        n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL wdg_conflict_cleared: got %b want 0", conflict); end
        req = 4'b0001;
        exp_q.push_back(0);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL wdg_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        busy_in = 4'b0001;
        held = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (grant === 4'b0001) begin
                held++;
            end else if (busy_in !== 4'b0000) begin
                busy_in = '0;
                req     = '0;
            end
        end
`ifdef MEM_ARB_WATCHDOG_EN
        n_cmp++; if (held !== 8) begin n_err++; $display("FAIL wdg_held: got %0d cycles want 8", held); end
        n_cmp++; if (wdog_err !== 1'b1) begin n_err++; $display("FAIL wdg_err: got %b want 1", wdog_err); end
`else
        n_cmp++; if (held !== 20) begin n_err++; $display("FAIL wdg_held: got %0d cycles want 20", held); end
        n_cmp++; if (wdog_err !== 1'b0) begin n_err++; $display("FAIL wdg_err: got %b want 0", wdog_err); end
`endif
        busy_in = '0;
        req     = '0;
        repeat (3) step();
        $display("test_watchdog: grant held %0d cycles, wdog_err=%b", held, wdog_err);
    endtask

    task automatic test_reset_mid_owned();
        req = 4'b0010;
        exp_q.push_back(1);
        step();
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== 4'(1 << sb_exp) || owner_id !== 2'(sb_exp)) begin
            n_err++; $display("FAIL rmo_grant: grant=%b owner=%0d want owner %0d", grant, owner_id, sb_exp);
        end
        busy_in = 4'b0010;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rmo_grant_drop: got %b want 0000", grant); end
        n_cmp++; if (owner_id !== 2'd0) begin n_err++; $display("FAIL rmo_owner: got %0d want 0", owner_id); end
        n_cmp++; if (bus_idle !== 1'b1) begin n_err++; $display("FAIL rmo_idle: got %b want 1", bus_idle); end
        n_cmp++; if (grant_timeout !== 1'b0 || conflict !== 1'b0 || wdog_err !== 1'b0) begin
            n_err++; $display("FAIL rmo_flags: timeout=%b conflict=%b wdog=%b want 0/0/0", grant_timeout, conflict, wdog_err);
        end
        busy_in = '0;
        req     = '0;
        step();
        reset = 1'b1;
        step();
        $display("test_reset_mid_owned: async reset cleared outputs mid-transfer");
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_timeout();
        test_withdraw();
        test_priority();
        test_conflict();
        test_watchdog();
        test_reset_mid_owned();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d expected grants never seen, want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Grants the shared memory interconnect to one of NREQ cache/bus clients (dcache, icache, DMA, …). It replaces the daisy-chained grant scheme with a central round-robin owner: exactly one client sees grant high, drives mem_addr/mem_data while it holds its busy line, then releases. The block sits beside the interconnect and sees each client's mem_req and bus_busy_out.

## Interface
- NREQ, 4: number of requesting clients (2..8)
- GRANT_TIMEOUT, 16: cycles a grant may wait for busy before revocation (≥2)
- WDOG_LIMIT, 256: max cycles one client may hold busy (watchdog build only)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-client mem_req, level
- busy_in  in  NREQ  per-client bus_busy_out, level
- grant  out  NREQ  one-hot (or zero) grant, registered
- owner_id  out  clog2(NREQ)  index of current/last grantee, registered
- bus_idle  out  1  high in IDLE only
- grant_timeout  out  1  one-cycle pulse on grant revocation by timeout
- conflict  out  1  sticky: illegal busy pattern seen
- wdog_err  out  1  sticky: hold-limit exceeded (0 when compiled out)

## Operation
- States: IDLE, GRANT, OWNED, TURN. Reset: IDLE, grant=0, owner_id=0, rr_ptr=0, bus_idle=1, grant_timeout=0, conflict=0, wdog_err=0.
- IDLE: if req≠0, winner = first set req bit scanning rr_ptr, rr_ptr+1, … mod NREQ; next state GRANT, grant=onehot(winner), owner_id=winner, gcnt=0. Else stay.
- GRANT: busy_in[owner]=1 → OWNED, hcnt=0. Else req[owner]=0 → TURN (request withdrawn). Else gcnt==GRANT_TIMEOUT-1 → TURN, grant_timeout pulse. Else gcnt+1. Busy takes priority over withdrawal/timeout in the same cycle.
- OWNED: grant held. busy_in[owner]=0 → TURN. hcnt increments, saturating.
- TURN: grant=0 for exactly one cycle (tristate turnaround); rr_ptr=(owner_id+1) mod NREQ, then IDLE. rr_ptr updates on every TURN entry regardless of cause.
- conflict set when popcount(busy_in)>1, or any busy_in bit other than owner is high while not IDLE, or any busy_in high in IDLE. Cleared only by reset. No state change on conflict.
- req bits of non-owners are ignored outside IDLE; grant never changes owner without passing through TURN.
- Reset mid-transfer: grant drops asynchronously; clients must abort.

## Timing
- req rising in IDLE at edge N → grant high after edge N+1 (1-cycle latency).
- busy falling at edge M → grant low after edge M+1 (TURN), bus_idle high after M+2; earliest next grant after M+3.
- Back-to-back owners: minimum 2 cycles of grant=0 between grants (TURN + IDLE arbitration).
- Timeout: grant high for exactly GRANT_TIMEOUT cycles, then grant_timeout pulses in the same cycle grant falls.
- Counters: gcnt width clog2(GRANT_TIMEOUT), hcnt width clog2(WDOG_LIMIT)+1; no wrap.

## Configuration
- MEM_ARB_WATCHDOG_EN defined: in OWNED, if hcnt reaches WDOG_LIMIT-1 with busy still high, force TURN, set wdog_err (sticky), grant falls next cycle. hcnt counter present.
- Undefined: no hcnt, OWNED exits only on busy release, wdog_err tied 0.

## Structure
- Package mem_arb_pkg: state encoding (IDLE=0, GRANT=1, OWNED=2, TURN=3), ID-width function clog2, default parameter constants.
- One sub-module: rr_pick — combinational round-robin priority encoder (req, rr_ptr → winner index, any_req).

## Test plan
- Single client: req[2]=1 from IDLE → grant=4'b0100 one cycle later; busy_in[2] held 5 cycles then dropped → grant low next cycle, bus_idle high the cycle after.
- Fairness: req=4'b1111 held, each client busy 3 cycles → owners 0,1,2,3,0 in order, two zero-grant cycles between each.
- Timeout: req[1]=1, busy never asserted, GRANT_TIMEOUT=16 → grant[1] high 16 cycles, grant_timeout pulse, then client 2 (if requesting) wins next.
- Withdrawal/priority: req[3] dropped in GRANT → TURN; busy and timeout same cycle → OWNED, no pulse.
- Conflict: busy_in=4'b0011 while owner=0 → conflict=1, stays 1 until reset; arbitration continues.
- Watchdog (macro on, WDOG_LIMIT=8): busy held 20 cycles → grant revoked after 8 OWNED cycles, wdog_err=1; macro off → grant held all 20 cycles, wdog_err=0. Assert reset mid-OWNED → all outputs to reset values immediately.
